// File: rtl/sseg_disp_arbiter_pkg.sv
// Shared definitions for the seven-segment display arbiter.
//   - FSM state encodings (IDLE, OWN, SWITCH)
//   - client index constants
//   - one-hot grant helper
package sseg_disp_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_OWN    = 2'd1;
    localparam logic [1:0] ST_SWITCH = 2'd2;

    localparam logic CLIENT0 = 1'b0;
    localparam logic CLIENT1 = 1'b1;

    // Client index -> one-hot grant vector.
    function automatic logic [1:0] gnt_onehot(input logic idx);
        return (idx == CLIENT1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sseg_rr_pick.sv
// Two-way round-robin pick.
//   i_req     per-client request
//   i_last    client served most recently
//   o_valid   at least one requester
//   o_winner  chosen client (lone requester, or the one not served last on a tie)
module sseg_rr_pick
    import sseg_disp_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_valid,
    output logic       o_winner
);

    always_comb begin
        o_valid = |i_req;
        unique case (i_req)
            2'b01:   o_winner = CLIENT0;
            2'b10:   o_winner = CLIENT1;
            2'b11:   o_winner = ~i_last;
            default: o_winner = i_last;  // no request; value unused
        endcase
    end

endmodule

// File: rtl/sseg_disp_arbiter.sv
// Shares one 4-digit scanned seven-segment display between two clients.
// Round-robin ownership with a minimum dwell time; one blanked cycle on a switch.
//   clk, reset          clock; asynchronous active-low reset
//   req[1:0]            per-client level request
//   frame0/dp0          client 0 digits {hex3,hex2,hex1,hex0} and decimal points
//   frame1/dp1          client 1 digits and decimal points
//   gnt[1:0]            registered one-hot grant, 00 when nobody owns
//   hex3..hex0, dp_out  registered display data for scan_led_disp
//   blank               high during the single switch-over cycle
module sseg_disp_arbiter
    import sseg_disp_arbiter_pkg::*;
#(
    parameter int unsigned DWELL   = 20,
    parameter int unsigned DWELL_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [15:0] frame0,
    input  logic [3:0]  dp0,
    input  logic [15:0] frame1,
    input  logic [3:0]  dp1,
    output logic [1:0]  gnt,
    output logic [3:0]  hex3,
    output logic [3:0]  hex2,
    output logic [3:0]  hex1,
    output logic [3:0]  hex0,
    output logic [3:0]  dp_out,
    output logic        blank
);

    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL);

    logic [1:0]         r_state, w_state_d;
    logic [1:0]         r_gnt, w_gnt_d;
    logic               r_blank, w_blank_d;
    logic [DWELL_W-1:0] r_dwell, w_dwell_d;
    logic               r_last, w_last_d;   // also the current owner while in OWN
    logic [15:0]        r_hex;
    logic [3:0]         r_dp;
    logic               w_load;
    logic               w_pick_valid;
    logic               w_pick;
    logic               w_other;

    assign w_other = ~r_last;

    sseg_rr_pick u_pick (
        .i_req    (req),
        .i_last   (r_last),
        .o_valid  (w_pick_valid),
        .o_winner (w_pick)
    );

    always_comb begin
        w_state_d = r_state;
        w_gnt_d   = r_gnt;
        w_blank_d = 1'b0;
        w_dwell_d = r_dwell;
        w_last_d  = r_last;
        w_load    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_gnt_d = 2'b00;
                if (w_pick_valid) begin
                    w_state_d = ST_OWN;
                    w_gnt_d   = gnt_onehot(w_pick);
                    w_dwell_d = '0;
                    w_last_d  = w_pick;
                end
            end
            ST_OWN: begin
                w_load = 1'b1;
                if (r_dwell != DWELL_MAX) begin
                    w_dwell_d = r_dwell + DWELL_W'(1);
                end
                // Owner release takes priority over a pending switch.
                if (!req[r_last]) begin
                    w_state_d = ST_IDLE;
                    w_gnt_d   = 2'b00;
                end else if (req[w_other] && (r_dwell == DWELL_MAX)) begin
                    w_state_d = ST_SWITCH;
                    w_gnt_d   = 2'b00;
                    w_blank_d = 1'b1;
                end
            end
            ST_SWITCH: begin
                if (req[w_other]) begin
                    w_state_d = ST_OWN;
                    w_gnt_d   = gnt_onehot(w_other);
                    w_dwell_d = '0;
                    w_last_d  = w_other;
                end else if (req[r_last]) begin
                    w_state_d = ST_OWN;
                    w_gnt_d   = gnt_onehot(r_last);
                    w_dwell_d = '0;
                end else begin
                    w_state_d = ST_IDLE;
                    w_gnt_d   = 2'b00;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_gnt   <= 2'b00;
            r_blank <= 1'b0;
            r_dwell <= '0;
            r_last  <= CLIENT1;   // client 0 wins the first tie
            r_hex   <= 16'h0000;
            r_dp    <= 4'h0;
        end else begin
            r_state <= w_state_d;
            r_gnt   <= w_gnt_d;
            r_blank <= w_blank_d;
            r_dwell <= w_dwell_d;
            r_last  <= w_last_d;
            if (w_load) begin
                r_hex <= (r_last == CLIENT1) ? frame1 : frame0;
                r_dp  <= (r_last == CLIENT1) ? dp1 : dp0;
            end
        end
    end

    assign gnt    = r_gnt;
    assign blank  = r_blank;
    assign hex3   = r_hex[15:12];
    assign hex2   = r_hex[11:8];
    assign hex1   = r_hex[7:4];
    assign hex0   = r_hex[3:0];
    assign dp_out = r_dp;

endmodule

// File: tb/tb_sseg_disp_arbiter.sv
// Directed bench for sseg_disp_arbiter (DWELL=20).
module tb_sseg_disp_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] frame0;
    logic [3:0]  dp0;
    logic [15:0] frame1;
    logic [3:0]  dp1;
    logic [1:0]  gnt;
    logic [3:0]  hex3, hex2, hex1, hex0;
    logic [3:0]  dp_out;
    logic        blank;

    int checks = 0;
    int errors = 0;

    sseg_disp_arbiter #(
        .DWELL   (20),
        .DWELL_W (5)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .frame0 (frame0),
        .dp0    (dp0),
        .frame1 (frame1),
        .dp1    (dp1),
        .gnt    (gnt),
        .hex3   (hex3),
        .hex2   (hex2),
        .hex1   (hex1),
        .hex0   (hex0),
        .dp_out (dp_out),
        .blank  (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] e_gnt,
                             input logic [15:0] e_hex, input logic [3:0] e_dp,
                             input logic e_blank);
        check({tag, ".gnt"}, {14'd0, gnt}, {14'd0, e_gnt});
        check({tag, ".hex"}, {hex3, hex2, hex1, hex0}, e_hex);
        check({tag, ".dp"}, {12'd0, dp_out}, {12'd0, e_dp});
        check({tag, ".blank"}, {15'd0, blank}, {15'd0, e_blank});
    endtask

    initial begin
        reset  = 1'b0;
        req    = 2'b11;
        frame0 = 16'h0000;
        dp0    = 4'h0;
        frame1 = 16'h0000;
        dp1    = 4'h0;

        // 1 Reset with both requesting, then client 0 wins the first tie
        #12;
        check_out("reset", 2'b00, 16'h0000, 4'h0, 1'b0);
        @(negedge clk) reset = 1'b1;
        step(1);
        check_out("first_tie", 2'b01, 16'h0000, 4'h0, 1'b0);
        req = 2'b00;
        step(1);
        check("release0.gnt", {14'd0, gnt}, 16'h0000);

        // 2 Single client 1, latency and long hold; non-owner frame ignored
        req    = 2'b10;
        frame1 = 16'h1234;
        dp1    = 4'b0100;
        step(1);
        check_out("single_gnt", 2'b10, 16'h0000, 4'h0, 1'b0);
        step(1);
        check_out("single_data", 2'b10, 16'h1234, 4'b0100, 1'b0);
        frame0 = 16'hFFFF;
        dp0    = 4'hF;
        step(100);
        check_out("single_hold", 2'b10, 16'h1234, 4'b0100, 1'b0);
        frame1 = 16'h5678;
        step(1);
        check("frame_update.hex", {hex3, hex2, hex1, hex0}, 16'h5678);
        req = 2'b00;
        step(1);
        check("release1.gnt", {14'd0, gnt}, 16'h0000);

        // 3 Contention: client 0 owns, client 1 raises at dwell 3
        frame0 = 16'hABCD;
        dp0    = 4'b0001;
        frame1 = 16'h1234;
        dp1    = 4'b0100;
        req    = 2'b01;
        step(1);
        check("cont_own0.gnt", {14'd0, gnt}, 16'h0001);
        step(3);
        req = 2'b11;
        step(17);
        check_out("cont_dwell20", 2'b01, 16'hABCD, 4'b0001, 1'b0);
        step(1);
        check_out("cont_switch", 2'b00, 16'hABCD, 4'b0001, 1'b1);
        step(1);
        check_out("cont_own1", 2'b10, 16'hABCD, 4'b0001, 1'b0);
        step(1);
        check_out("cont_data1", 2'b10, 16'h1234, 4'b0100, 1'b0);
        req = 2'b00;
        step(1);
        check("release2.gnt", {14'd0, gnt}, 16'h0000);

        // 4 Owner 0 releases at dwell 5; display frozen in IDLE
        frame0 = 16'h2468;
        dp0    = 4'b0010;
        req    = 2'b01;
        step(1);
        step(5);
        req = 2'b00;
        step(1);
        check_out("drop_idle", 2'b00, 16'h2468, 4'b0010, 1'b0);
        frame0 = 16'h9999;
        dp0    = 4'b1000;
        step(2);
        check_out("drop_frozen", 2'b00, 16'h2468, 4'b0010, 1'b0);

        // 5 Round-robin tie after client 0 served -> client 1
        req = 2'b11;
        step(1);
        check("rr_tie.gnt", {14'd0, gnt}, 16'h0002);

        // Owner drop coincident with other request: IDLE gap, then grant
        req = 2'b01;
        step(1);
        check("drop_other_gap.gnt", {14'd0, gnt}, 16'h0000);
        check("drop_other_gap.blank", {15'd0, blank}, 16'h0000);
        step(1);
        check("drop_other_gnt.gnt", {14'd0, gnt}, 16'h0001);

        // 6 Async reset mid-ownership at dwell 10
        step(10);
        check("pre_reset.hex", {hex3, hex2, hex1, hex0}, 16'h9999);
        #2 reset = 1'b0;
        #1;
        check_out("async_reset", 2'b00, 16'h0000, 4'h0, 1'b0);
        req = 2'b11;
        step(1);
        @(negedge clk) reset = 1'b1;
        step(1);
        check("post_reset_tie.gnt", {14'd0, gnt}, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
